// File: rtl/bitorder_pkg.sv
// Shared types and constants for the RMII receive dibit-to-byte assembler.
package bitorder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_e;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;
  localparam int         BYTE_CNT_W     = 11;

endpackage

// File: rtl/bitorder_in.sv
// RMII receive assembler: finds preamble/SFD, packs dibits LSB-first into bytes.
// Define BITORDER_IN_BYTE_COUNT_EN to expose the per-frame byte_count output.
module bitorder_in
  import bitorder_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       frame_done,
  output logic       frame_err
`ifdef BITORDER_IN_BYTE_COUNT_EN
  ,
  output logic [BYTE_CNT_W-1:0] byte_count
`endif
);

  localparam int PW = $clog2(MIN_PREAMBLE_DIBITS + 1);
  localparam logic [PW-1:0] PMIN = PW'(MIN_PREAMBLE_DIBITS);

`ifdef BITORDER_IN_BYTE_COUNT_EN
  localparam int CW = BYTE_CNT_W;
`else
  localparam int CW = 1;
`endif

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [5:0]    shift_q, shift_d;
  logic [7:0]    axiod_q, axiod_d;
  logic          axiov_q, axiov_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Without the feature the saturating counter degenerates to a seen flag
  logic byte_seen;
  assign byte_seen = (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    shift_d = shift_q;
    axiod_d = axiod_q;
    axiov_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (axiiv) begin
          if (axiid == PREAMBLE_DIBIT) begin
            state_d = PREAMBLE;
            pcnt_d  = PW'(1);
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!axiiv) begin
          state_d = IDLE;
        end else if (axiid == PREAMBLE_DIBIT) begin
          if (pcnt_q < PMIN) pcnt_d = pcnt_q + 1'b1;
        end else if (axiid == SFD_DIBIT && pcnt_q >= PMIN) begin
          state_d = DATA;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (axiiv) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: shift_d[1:0] = axiid;
            2'd1: shift_d[3:2] = axiid;
            2'd2: shift_d[5:4] = axiid;
            2'd3: begin
              axiov_d = 1'b1;
              axiod_d = {axiid, shift_q};
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
            default: ;
          endcase
        end else begin
          state_d = IDLE;
          if (idx_q == 2'd0 && byte_seen) done_d = 1'b1;
          else                            err_d  = 1'b1;
        end
      end
      DROP: begin
        if (!axiiv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pcnt_q  <= '0;
      shift_q <= '0;
      axiod_q <= '0;
      axiov_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      shift_q <= shift_d;
      axiod_q <= axiod_d;
      axiov_q <= axiov_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
`ifdef BITORDER_IN_BYTE_COUNT_EN
  assign byte_count = cnt_q;
`endif

endmodule

// File: tb/tb_bitorder_in.sv
// Scoreboard bench for bitorder_in: frame-level reference model feeds
// expected bytes/end events; a negedge monitor pops and compares.
module tb_bitorder_in;

  localparam int MIN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       axiov;
  logic [7:0] axiod;
  logic       frame_done;
  logic       frame_err;
`ifdef BITORDER_IN_BYTE_COUNT_EN
  logic [10:0] byte_count;
`endif

  bitorder_in #(.MIN_PREAMBLE_DIBITS(MIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .axiov      (axiov),
    .axiod      (axiod),
    .frame_done (frame_done),
    .frame_err  (frame_err)
`ifdef BITORDER_IN_BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } bexp_t;

  typedef struct {
    int cyc;
    bit err;
    int nb;
  } eexp_t;

  bexp_t      bq[$];
  eexp_t      eq[$];
  logic [1:0] fq[$];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_zero = 0;
  bit final_chk = 0;
  bit final_done = 0;

  always @(negedge clk) begin
    bexp_t be;
    eexp_t ee;
    if (chk_zero) begin
      n_chk += 4;
      if (axiov !== 1'b0) begin
        n_fail++; $display("FAIL zero_axiov got %b want 0", axiov);
      end
      if (axiod !== 8'h00) begin
        n_fail++; $display("FAIL zero_axiod got %h want 00", axiod);
      end
      if (frame_done !== 1'b0) begin
        n_fail++; $display("FAIL zero_done got %b want 0", frame_done);
      end
      if (frame_err !== 1'b0) begin
        n_fail++; $display("FAIL zero_err got %b want 0", frame_err);
      end
    end else begin
      if (axiov === 1'b1) begin
        n_chk++;
        if (bq.size() == 0) begin
          n_fail++;
          $display("FAIL byte_unexpected cyc %0d got %h want none", cyc, axiod);
        end else begin
          be = bq.pop_front();
          if (be.cyc != cyc || axiod !== be.b) begin
            n_fail++;
            $display("FAIL byte cyc %0d data %h want cyc %0d data %h",
                     cyc, axiod, be.cyc, be.b);
          end
        end
      end
      if (frame_done === 1'b1 || frame_err === 1'b1) begin
        n_chk++;
        if (eq.size() == 0) begin
          n_fail++;
          $display("FAIL end_unexpected cyc %0d done %b err %b want none",
                   cyc, frame_done, frame_err);
        end else begin
          ee = eq.pop_front();
          if (ee.cyc != cyc || frame_err !== ee.err ||
              frame_done !== !ee.err || axiov === 1'b1) begin
            n_fail++;
            $display("FAIL end cyc %0d done %b err %b ov %b want cyc %0d err %b",
                     cyc, frame_done, frame_err, axiov, ee.cyc, ee.err);
          end
`ifdef BITORDER_IN_BYTE_COUNT_EN
          n_chk++;
          if (byte_count != 11'(ee.nb)) begin
            n_fail++;
            $display("FAIL byte_count got %0d want %0d", byte_count, ee.nb);
          end
`endif
        end
      end
    end
    if (final_chk && !final_done) begin
      n_chk++;
      if (bq.size() != 0 || eq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover bytes %0d ends %0d want 0 0",
                 bq.size(), eq.size());
      end
      final_done = 1;
    end
  end

  task automatic add(input logic [1:0] d);
    fq.push_back(d);
  endtask

  task automatic addn(input logic [1:0] d, input int n);
    for (int k = 0; k < n; k++) fq.push_back(d);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) fq.push_back(2'(b >> (2 * k)));
  endtask

  // Frame-level model: dibit i of the burst is sampled at cycle s+i
  task automatic model(input int s, input bit with_end);
    int i = 0;
    int run = 0;
    int n = fq.size();
    int m;
    int nb;
    logic [7:0] b;
    while (i < n && fq[i] == 2'b01) begin
      run++;
      i++;
    end
    if (i == n || fq[i] != 2'b11 || run < MIN) return;
    m = n - i - 1;
    nb = m / 4;
    for (int j = 0; j < nb; j++) begin
      b = {fq[i+4*j+4], fq[i+4*j+3], fq[i+4*j+2], fq[i+4*j+1]};
      bq.push_back('{s + i + 4*j + 4, b});
    end
    if (with_end) eq.push_back('{s + n, (m % 4 != 0) || nb == 0, nb});
  endtask

  // Entered and left at posedge+1
  task automatic run_frame(input bit with_end);
    model(cyc + 1, with_end);
    foreach (fq[i]) begin
      axiiv = 1'b1;
      axiid = fq[i];
      @(posedge clk); #1;
    end
    if (with_end) begin
      axiiv = 1'b0;
      axiid = 2'($urandom);
      @(posedge clk); #1;
    end
    fq.delete();
  endtask

  task automatic idle(input int n);
    axiiv = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic preamble_sfd();
    addn(2'b01, MIN);
    add(2'b11);
  endtask

  initial begin
    int kind;
    repeat (3) @(posedge clk);
    #1 chk_zero = 1;
    @(negedge clk); #1 chk_zero = 0;
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    addn(2'b01, 28); add(2'b11);
    add(2'b11); add(2'b10); add(2'b10); add(2'b10);
    add(2'b10); add(2'b00); add(2'b01); add(2'b00);
    run_frame(1);
    idle(2);

    addn(2'b01, 4); add(2'b11); add_byte(8'hAB); add_byte(8'h5C);
    run_frame(1);
    idle(1);

    preamble_sfd(); add_byte(8'hAB); add(2'b01); add(2'b01);
    run_frame(1);
    idle(1);

    addn(2'b01, 4); add(2'b00); addn(2'b01, 10); add(2'b11);
    add_byte(8'h33);
    run_frame(1);
    preamble_sfd(); add_byte(8'hC4);
    run_frame(1);
    idle(1);

    preamble_sfd(); add_byte(8'h96); add(2'b10); add(2'b11);
    run_frame(0);
    rst = 1'b1;
    axiiv = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    chk_zero = 1;
    @(negedge clk); #1 chk_zero = 0;
    idle(1);
    preamble_sfd(); add_byte(8'h7E); add_byte(8'h01);
    run_frame(1);

    preamble_sfd();
    run_frame(1);
    preamble_sfd(); add_byte(8'hFF);
    run_frame(1);
    idle(1);

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          addn(2'b01, $urandom_range(MIN, MIN + 12)); add(2'b11);
        end
        1: begin
          addn(2'b01, $urandom_range(1, MIN - 1)); add(2'b11);
        end
        2: ;
        default: begin
          addn(2'b01, $urandom_range(1, 10));
          add(2'($urandom_range(0, 1) * 2));
        end
      endcase
      for (int k = $urandom_range(kind == 2 ? 1 : 0, 24); k > 0; k--)
        add(2'($urandom));
      run_frame(1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    final_chk = 1;
    repeat (2) @(negedge clk);
    if (!final_done) begin
      $display("FAIL final_check not reached");
      $fatal(1, "final check timeout");
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
